branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Consumer end of the branch-buffer issue interface. Accepts one issued branch/jump per cycle.
//  Reads its target register and condition flag from the physical register files.
//  Resolves taken/target, writes the jump link value, and reports completion to the ROB.
//  On a mispredict, drives the fetch redirect and a timed recovery flush.
// PARAMETERS
//  PC_W         `PC_SIZE                 PC width
//  DATA_W       16                       data register width (>= PC_W)
//  DREG_AW      $clog2(`NUM_D_REG)       data physical-register address width
//  SREG_AW      $clog2(`NUM_S_REG)       status physical-register address width
//  ROB_AW       5                        ROB index width
//  FLUSH_CYCLES 2                        cycles flush is held after a mispredict (>=1)
// PORTS
//  clk               in   1        clock
//  n_rst             in   1        reset: asynchronous, active-low
//  in_valid          in   1        issued branch valid
//  in_ready          out  1        unit can accept this cycle
//  in_rob_addr       in   ROB_AW   ROB slot of branch
//  in_jump           in   1        1 = unconditional jump, 0 = conditional branch
//  in_predict_taken  in   1        fetch prediction
//  in_pc             in   PC_W     branch PC
//  in_predict_target in   PC_W     predicted target
//  in_rt_addr        in   DREG_AW  target register (physical)
//  in_rw_addr        in   DREG_AW  link destination (physical), jumps only
//  in_rs_addr        in   SREG_AW  condition flag register (physical)
//  rf_rt_addr        out  DREG_AW  data RF read address (= in_rt_addr, combinational)
//  rf_rt_data        in   DATA_W   data RF read data, valid 1 cycle after address
//  sf_rs_addr        out  SREG_AW  status RF read address (= in_rs_addr, combinational)
//  sf_rs_data        in   1        status flag, valid 1 cycle after address
//  kill              in   1        ROB squash: drop all in-flight work
//  wb_valid          out  1        link write enable
//  wb_addr           out  DREG_AW  link write address
//  wb_data           out  DATA_W   link value, zero-extended pc+1
//  done_valid        out  1        resolution result valid (single-cycle pulse per branch)
//  done_rob_addr     out  ROB_AW   ROB slot resolved
//  done_mispredict   out  1        prediction was wrong
//  redirect_valid    out  1        fetch redirect (= done_valid & done_mispredict)
//  redirect_pc       out  PC_W     correct next PC
//  flush             out  1        recovery flush to front end / rename
// BEHAVIOUR
//  - Reset: all outputs 0 except in_ready=1; S1/S2 valid=0; state RUN.
//  - Pipeline:
//    - Accept when in_valid & in_ready; fields latch into S1.
//    - Next cycle: S1 combines rf_rt_data / sf_rs_data and registers the result into S2.
//    - S2 drives all result outputs, so latency is 2 cycles from accept to done_valid.
//  - Resolution:
//    - taken = jump | sf_rs_data.
//    - target = taken ? rf_rt_data[PC_W-1:0] : pc+1. pc+1 wraps modulo 2^PC_W.
//    - mispredict = (taken != predict_taken) | (taken & target != predict_target).
//    - redirect_pc = target.
//  - Link write: wb_valid = S2 valid & jump; wb_data = pc+1 zero-extended; same cycle as done_valid.
//  - FSM:
//    - RUN: in_ready = ~kill. S2 mispredict -> RECOVER, counter loaded with FLUSH_CYCLES-1.
//    - RECOVER: flush=1, in_ready=0; count down. When count==0 -> RUN at the next edge.
//    - flush is registered and is first high the cycle after redirect_valid.
//  - S1 entry in flight at mispredict time completes normally; the ROB orders squash.
//  - kill: S1/S2 valid cleared at the next edge; no done/wb for them; FSM -> RUN; counter cleared.
//    - kill wins over a simultaneous accept or mispredict.
//  - Back-to-back: one accept per cycle in RUN, so done_valid can pulse every cycle.
//  - Reset mid-RECOVER: immediate return to the reset state.
// TESTING
//  1 Jump rt=0x0040, pred taken, target 0x0040, pc=0x10 -> 2 cyc later: done, mispredict=0,
//    wb rw<=0x0011, no flush.
//  2 Branch flag=0, pred taken, pc=0x20 -> mispredict=1, redirect_pc=0x21;
//    flush high for 2 cycles; in_ready=0 for those 2.
//  3 Branch flag=1, pred taken, rt=0x50, predict_target=0x54 -> mispredict=1, redirect_pc=0x50.
//  4 pc=all-ones, not-taken, predicted not taken -> target wraps to 0, mispredict=0, wb_valid=0.
//  5 Issue 3 branches on consecutive cycles, assert kill with the 2nd -> only the 1st completes;
//    the 3rd accepted only if kill is low that cycle.
//  6 Deassert n_rst during RECOVER -> flush=0, in_ready=1 asynchronously; no stale done pulse.

Source files
------------

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// branch_resolve_unit: resolves issued branches/jumps, writes links, redirects
// fetch and drives a timed recovery flush.                          rev 1.0
// ============================================================================
`ifndef PC_SIZE
`define PC_SIZE 16
`endif
`ifndef NUM_D_REG
`define NUM_D_REG 32
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 16
`endif

module branch_resolve_unit #(
  parameter int PC_W         = `PC_SIZE,
  parameter int DATA_W       = 16,
  parameter int DREG_AW      = $clog2(`NUM_D_REG),
  parameter int SREG_AW      = $clog2(`NUM_S_REG),
  parameter int ROB_AW       = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ROB_AW-1:0]  in_rob_addr,
  input  logic               in_jump,
  input  logic               in_predict_taken,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [PC_W-1:0]    in_predict_target,
  input  logic [DREG_AW-1:0] in_rt_addr,
  input  logic [DREG_AW-1:0] in_rw_addr,
  input  logic [SREG_AW-1:0] in_rs_addr,
  output logic [DREG_AW-1:0] rf_rt_addr,
  input  logic [DATA_W-1:0]  rf_rt_data,
  output logic [SREG_AW-1:0] sf_rs_addr,
  input  logic               sf_rs_data,
  input  logic               kill,
  output logic               wb_valid,
  output logic [DREG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               done_valid,
  output logic [ROB_AW-1:0]  done_rob_addr,
  output logic               done_mispredict,
  output logic               redirect_valid,
  output logic [PC_W-1:0]    redirect_pc,
  output logic               flush
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  // S1: issued fields awaiting register-file read data
  logic               s1_valid;
  logic [ROB_AW-1:0]  s1_rob;
  logic               s1_jump;
  logic               s1_ptaken;
  logic [PC_W-1:0]    s1_pc;
  logic [PC_W-1:0]    s1_ptarget;
  logic [DREG_AW-1:0] s1_rw;

  // S2: resolved result, drives all outputs
  logic               s2_valid;
  logic [ROB_AW-1:0]  s2_rob;
  logic               s2_jump;
  logic               s2_mispredict;
  logic [PC_W-1:0]    s2_target;
  logic [DREG_AW-1:0] s2_rw;
  logic [DATA_W-1:0]  s2_link;

  logic               accept;
  logic               taken;
  logic [PC_W-1:0]    pc_plus1;
  logic [PC_W-1:0]    target;
  logic               mispredict;

  assign rf_rt_addr = in_rt_addr;
  assign sf_rs_addr = in_rs_addr;
  assign in_ready   = (state == RUN) && !kill;
  assign accept     = in_valid && in_ready;

  assign pc_plus1   = s1_pc + PC_W'(1);
  assign taken      = s1_jump | sf_rs_data;
  assign target     = taken ? rf_rt_data[PC_W-1:0] : pc_plus1;
  assign mispredict = (taken != s1_ptaken) | (taken & (target != s1_ptarget));

  generate
    if (DATA_W > PC_W) begin : g_unused_hi
      logic unused_rt_hi;
      assign unused_rt_hi = ^rf_rt_data[DATA_W-1:PC_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid   <= 1'b0;
      s1_rob     <= '0;
      s1_jump    <= 1'b0;
      s1_ptaken  <= 1'b0;
      s1_pc      <= '0;
      s1_ptarget <= '0;
      s1_rw      <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_rob     <= in_rob_addr;
        s1_jump    <= in_jump;
        s1_ptaken  <= in_predict_taken;
        s1_pc      <= in_pc;
        s1_ptarget <= in_predict_target;
        s1_rw      <= in_rw_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s2_valid      <= 1'b0;
      s2_rob        <= '0;
      s2_jump       <= 1'b0;
      s2_mispredict <= 1'b0;
      s2_target     <= '0;
      s2_rw         <= '0;
      s2_link       <= '0;
    end else begin
      s2_valid <= s1_valid && !kill;
      if (s1_valid) begin
        s2_rob        <= s1_rob;
        s2_jump       <= s1_jump;
        s2_mispredict <= mispredict;
        s2_target     <= target;
        s2_rw         <= s1_rw;
        s2_link       <= DATA_W'(pc_plus1);
      end
    end
  end

  assign done_valid      = s2_valid;
  assign done_rob_addr   = s2_rob;
  assign done_mispredict = s2_valid & s2_mispredict;
  assign redirect_valid  = s2_valid & s2_mispredict;
  assign redirect_pc     = s2_target;
  assign wb_valid        = s2_valid & s2_jump;
  assign wb_addr         = s2_rw;
  assign wb_data         = s2_link;
  assign flush           = (state == RECOVER);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (s2_valid && s2_mispredict) begin
          state_nxt = RECOVER;
          cnt_nxt   = FLUSH_LOAD;
        end
      end
      RECOVER: begin
        if (cnt == '0) state_nxt = RUN;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = RUN;
    endcase
    // squash overrides any recovery in progress or about to start
    if (kill) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// tb_branch_resolve_unit: directed self-checking bench for branch_resolve_unit.
// ============================================================================
module tb_branch_resolve_unit;

  localparam int PC_W = 16, DATA_W = 16, DREG_AW = 5, SREG_AW = 4, ROB_AW = 5;

  logic               clk = 1'b0;
  logic               n_rst;
  logic               in_valid;
  logic               in_ready;
  logic [ROB_AW-1:0]  in_rob_addr;
  logic               in_jump;
  logic               in_predict_taken;
  logic [PC_W-1:0]    in_pc;
  logic [PC_W-1:0]    in_predict_target;
  logic [DREG_AW-1:0] in_rt_addr;
  logic [DREG_AW-1:0] in_rw_addr;
  logic [SREG_AW-1:0] in_rs_addr;
  logic [DREG_AW-1:0] rf_rt_addr;
  logic [DATA_W-1:0]  rf_rt_data;
  logic [SREG_AW-1:0] sf_rs_addr;
  logic               sf_rs_data;
  logic               kill;
  logic               wb_valid;
  logic [DREG_AW-1:0] wb_addr;
  logic [DATA_W-1:0]  wb_data;
  logic               done_valid;
  logic [ROB_AW-1:0]  done_rob_addr;
  logic               done_mispredict;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               flush;

  int vectors = 0;
  int errors  = 0;

  logic [DATA_W-1:0] drf [32];
  logic              sfr [16];

  always #5 clk = ~clk;

  // register files: one-cycle read latency
  always @(posedge clk) begin
    rf_rt_data <= drf[rf_rt_addr];
    sf_rs_data <= sfr[sf_rs_addr];
  end

  branch_resolve_unit #(
    .PC_W(PC_W), .DATA_W(DATA_W), .DREG_AW(DREG_AW), .SREG_AW(SREG_AW),
    .ROB_AW(ROB_AW), .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rob_addr(in_rob_addr),
    .in_jump(in_jump), .in_predict_taken(in_predict_taken), .in_pc(in_pc),
    .in_predict_target(in_predict_target), .in_rt_addr(in_rt_addr),
    .in_rw_addr(in_rw_addr), .in_rs_addr(in_rs_addr),
    .rf_rt_addr(rf_rt_addr), .rf_rt_data(rf_rt_data),
    .sf_rs_addr(sf_rs_addr), .sf_rs_data(sf_rs_data), .kill(kill),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .done_valid(done_valid), .done_rob_addr(done_rob_addr),
    .done_mispredict(done_mispredict), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush)
  );

  // drive one issue slot just after a rising edge
  task automatic drive(input logic v, input logic [ROB_AW-1:0] rob, input logic j,
                       input logic pt, input logic [PC_W-1:0] pc,
                       input logic [PC_W-1:0] ptgt, input logic [DREG_AW-1:0] rt,
                       input logic [DREG_AW-1:0] rw, input logic [SREG_AW-1:0] rs);
    @(posedge clk); #1;
    in_valid = v; in_rob_addr = rob; in_jump = j; in_predict_taken = pt;
    in_pc = pc; in_predict_target = ptgt; in_rt_addr = rt; in_rw_addr = rw;
    in_rs_addr = rs;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    vectors++; if ({done_valid, wb_valid, redirect_valid, flush, done_mispredict} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000", {done_valid, wb_valid, redirect_valid, flush, done_mispredict}); end
    vectors++; if ({wb_data, redirect_pc, done_rob_addr} !== '0) begin
      errors++; $display("FAIL reset_data got=%0h exp=0", {wb_data, redirect_pc, done_rob_addr}); end
    n_rst = 1'b1;
  endtask

  task automatic test_jump_link();
    drf[3] = 16'h0040;
    drive(1'b1, 5'd1, 1'b1, 1'b1, 16'h0010, 16'h0040, 5'd3, 5'd7, 4'd0);
    idle();
    @(posedge clk); @(negedge clk);
    vectors++; if (done_valid !== 1'b1 || done_rob_addr !== 5'd1) begin errors++; $display("FAIL jump_done got=%0h/%0d exp=1/1", done_valid, done_rob_addr); end
    vectors++; if (done_mispredict !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL jump_mispredict got=%0h exp=0", done_mispredict); end
    vectors++; if (wb_valid !== 1'b1 || wb_addr !== 5'd7 || wb_data !== 16'h0011) begin
      errors++; $display("FAIL jump_wb got=%0h/%0d/%0h exp=1/7/11", wb_valid, wb_addr, wb_data); end
    @(negedge clk);
    vectors++; if (done_valid !== 1'b0 || flush !== 1'b0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL jump_after got=%0h%0h%0h exp=000", done_valid, flush, wb_valid); end
  endtask

  task automatic test_not_taken_mispredict();
    sfr[1] = 1'b0;
    drive(1'b1, 5'd2, 1'b0, 1'b1, 16'h0020, 16'h0099, 5'd3, 5'd0, 4'd1);
    idle();
    @(posedge clk); @(negedge clk);
    vectors++; if (done_mispredict !== 1'b1 || redirect_valid !== 1'b1) begin errors++; $display("FAIL nt_mispredict got=%0h%0h exp=11", done_mispredict, redirect_valid); end
    vectors++; if (redirect_pc !== 16'h0021) begin errors++; $display("FAIL nt_redirect_pc got=%0h exp=21", redirect_pc); end
    vectors++; if (wb_valid !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL nt_wb_flush got=%0h%0h exp=00", wb_valid, flush); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++; if (flush !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL nt_recover%0d got=%0h%0h exp=10", i, flush, in_ready); end
    end
    @(negedge clk);
    vectors++; if (flush !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL nt_recover_end got=%0h%0h exp=01", flush, in_ready); end
  endtask

  task automatic test_wrong_target();
    sfr[2] = 1'b1; drf[4] = 16'h0050;
    drive(1'b1, 5'd3, 1'b0, 1'b1, 16'h0030, 16'h0054, 5'd4, 5'd0, 4'd2);
    idle();
    @(posedge clk); @(negedge clk);
    vectors++; if (done_mispredict !== 1'b1 || redirect_pc !== 16'h0050) begin
      errors++; $display("FAIL tgt_redirect got=%0h/%0h exp=1/50", done_mispredict, redirect_pc); end
    repeat (3) @(negedge clk);
    vectors++; if (flush !== 1'b0) begin errors++; $display("FAIL tgt_flush_end got=%0h exp=0", flush); end
  endtask

  task automatic test_pc_wrap();
    sfr[0] = 1'b0;
    drive(1'b1, 5'd4, 1'b0, 1'b0, 16'hFFFF, 16'h1234, 5'd3, 5'd0, 4'd0);
    idle();
    @(posedge clk); @(negedge clk);
    vectors++; if (done_valid !== 1'b1 || done_mispredict !== 1'b0) begin errors++; $display("FAIL wrap_done got=%0h%0h exp=10", done_valid, done_mispredict); end
    vectors++; if (redirect_pc !== 16'h0000 || wb_valid !== 1'b0) begin errors++; $display("FAIL wrap_target got=%0h/%0h exp=0/0", redirect_pc, wb_valid); end
  endtask

  task automatic test_back_to_back();
    sfr[3] = 1'b1; drf[5] = 16'h0100;
    drive(1'b1, 5'd5, 1'b0, 1'b0, 16'h0040, 16'h0000, 5'd5, 5'd0, 4'd0);
    drive(1'b1, 5'd6, 1'b0, 1'b1, 16'h0041, 16'h0100, 5'd5, 5'd0, 4'd3);
    drive(1'b1, 5'd7, 1'b1, 1'b1, 16'h0042, 16'h0100, 5'd5, 5'd9, 4'd0);
    @(negedge clk);
    vectors++; if (done_valid !== 1'b1 || done_rob_addr !== 5'd5 || done_mispredict !== 1'b0) begin
      errors++; $display("FAIL b2b_0 got=%0h/%0d/%0h exp=1/5/0", done_valid, done_rob_addr, done_mispredict); end
    idle();
    @(negedge clk);
    vectors++; if (done_valid !== 1'b1 || done_rob_addr !== 5'd6 || done_mispredict !== 1'b0) begin
      errors++; $display("FAIL b2b_1 got=%0h/%0d/%0h exp=1/6/0", done_valid, done_rob_addr, done_mispredict); end
    @(negedge clk);
    vectors++; if (done_valid !== 1'b1 || done_rob_addr !== 5'd7 || wb_data !== 16'h0043 || done_mispredict !== 1'b0) begin
      errors++; $display("FAIL b2b_2 got=%0h/%0d/%0h exp=1/7/43", done_valid, done_rob_addr, wb_data); end
    @(negedge clk);
    vectors++; if (done_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got=%0h exp=0", done_valid); end
  endtask

  // kill raised while the 1st branch sits in S2 and the 2nd in S1
  task automatic test_kill();
    drive(1'b1, 5'd10, 1'b0, 1'b0, 16'h0060, 16'h0000, 5'd3, 5'd0, 4'd0);
    drive(1'b1, 5'd11, 1'b0, 1'b1, 16'h0061, 16'h0000, 5'd3, 5'd0, 4'd0);
    drive(1'b1, 5'd12, 1'b0, 1'b0, 16'h0062, 16'h0000, 5'd3, 5'd0, 4'd0);
    kill = 1'b1;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL kill_ready got=%0h exp=0", in_ready); end
    vectors++; if (done_valid !== 1'b1 || done_rob_addr !== 5'd10) begin errors++; $display("FAIL kill_first got=%0h/%0d exp=1/10", done_valid, done_rob_addr); end
    @(posedge clk); #1; kill = 1'b0;
    @(negedge clk);
    vectors++; if (done_valid !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL kill_second got=%0h%0h exp=00", done_valid, flush); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL kill_ready_back got=%0h exp=1", in_ready); end
    idle();
    @(negedge clk);
    vectors++; if (done_valid !== 1'b0) begin errors++; $display("FAIL kill_gap got=%0h exp=0", done_valid); end
    @(negedge clk);
    vectors++; if (done_valid !== 1'b1 || done_rob_addr !== 5'd12) begin errors++; $display("FAIL kill_third got=%0h/%0d exp=1/12", done_valid, done_rob_addr); end
  endtask

  task automatic test_reset_in_recover();
    drive(1'b1, 5'd13, 1'b0, 1'b1, 16'h0070, 16'h0000, 5'd3, 5'd0, 4'd0);
    idle();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    vectors++; if (flush !== 1'b1) begin errors++; $display("FAIL rr_in_recover got=%0h exp=1", flush); end
    #2 n_rst = 1'b0;
    #1;
    vectors++; if (flush !== 1'b0 || in_ready !== 1'b1 || done_valid !== 1'b0) begin
      errors++; $display("FAIL rr_async got=%0h%0h%0h exp=010", flush, in_ready, done_valid); end
    @(negedge clk); n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (done_valid !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL rr_after%0d got=%0h%0h exp=00", i, done_valid, flush); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) drf[i] = '0;
    for (int i = 0; i < 16; i++) sfr[i] = 1'b0;
    in_valid = 1'b0; in_rob_addr = '0; in_jump = 1'b0; in_predict_taken = 1'b0;
    in_pc = '0; in_predict_target = '0; in_rt_addr = '0; in_rw_addr = '0;
    in_rs_addr = '0; kill = 1'b0;
    test_reset();
    test_jump_link();
    test_not_taken_mispredict();
    test_wrong_target();
    test_pc_wrap();
    test_back_to_back();
    test_kill();
    test_reset_in_recover();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
